// File: rtl/irrigation_sequencer.sv
// Tank-aware irrigation controller: picks sprinkler or drip, refills the tank on low level,
// and latches a fault on inconsistent level sensors or refill timeout. Timers count down in BCD.
module irrigation_sequencer #(
  parameter logic [15:0] SPRINKLE_MMSS = 16'h0300,
  parameter logic [15:0] DRIP_MMSS     = 16'h0500,
  parameter logic [15:0] FILL_MMSS     = 16'h0130
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        high_level_indicator_i,
  input  logic        middle_level_indicator_i,
  input  logic        low_level_indicator_i,
  input  logic        soil_humidity_i,
  input  logic        air_humidity_i,
  input  logic        start_i,
  input  logic        ack_i,
  output logic        sprinkler_o,
  output logic        drip_o,
  output logic        inlet_valve_o,
  output logic        alarm_o,
  output logic        error_o,
  output logic [2:0]  state_o,
  output logic [15:0] time_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StCheck    = 3'd1,
    StSprinkle = 3'd2,
    StDrip     = 3'd3,
    StFill     = 3'd4,
    StFault    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        high, middle, low, err, expired;

  assign high    = high_level_indicator_i;
  assign middle  = middle_level_indicator_i;
  assign low     = low_level_indicator_i;
  assign err     = (high & ~middle) | (middle & ~low);
  assign expired = tick_i && (cnt_q == 16'h0000);

  // Only called with a nonzero value, so min_tens never underflows.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) begin
          r[11:8] = v[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q > StFault) begin
      state_d = StIdle;
      cnt_d   = 16'h0000;
    end else if (err) begin
      state_d = StFault;
      cnt_d   = 16'h0000;
    // FAULT is sticky: only an acknowledge leaves it, a low tank does not.
    end else if (!low && state_q != StFill && state_q != StFault) begin
      state_d = StFill;
      cnt_d   = FILL_MMSS;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = 16'h0000;
          if (start_i || !soil_humidity_i) state_d = StCheck;
        end
        StCheck: begin
          if (middle && !air_humidity_i) begin
            state_d = StSprinkle;
            cnt_d   = SPRINKLE_MMSS;
          end else begin
            state_d = StDrip;
            cnt_d   = DRIP_MMSS;
          end
        end
        StSprinkle: begin
          if (expired) begin
            state_d = StIdle;
          end else if (!middle) begin
            state_d = StDrip;
          end else if (tick_i) begin
            cnt_d = bcd_dec(cnt_q);
          end
        end
        StDrip: begin
          if (expired) state_d = StIdle;
          else if (tick_i) cnt_d = bcd_dec(cnt_q);
        end
        StFill: begin
          if (high) begin
            state_d = StIdle;
            cnt_d   = 16'h0000;
          end else if (expired) begin
            state_d = StFault;
          end else if (tick_i) begin
            cnt_d = bcd_dec(cnt_q);
          end
        end
        StFault: begin
          cnt_d = 16'h0000;
          if (ack_i) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 16'h0000;
        end
      endcase
    end
  end

  always_comb begin
    sprinkler_o   = (state_q == StSprinkle);
    drip_o        = (state_q == StDrip);
    inlet_valve_o = (state_q == StFill);
    alarm_o       = (state_q == StFault) || !low;
    error_o       = err;
    state_o       = state_q;
    time_o        = cnt_q;
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scenario bench for irrigation_sequencer: expectations are queued as stimulus is applied and
// drained after the following clock edge.
module tb_irrigation_sequencer;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] SPRINKLE = 3'd2;
  localparam logic [2:0] DRIP     = 3'd3;
  localparam logic [2:0] FILL     = 3'd4;
  localparam logic [2:0] FAULT    = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n, tick, high, mid, low, soil, air, start, ack;
  logic        sprinkler, drip, inlet, alarm, error;
  logic [2:0]  state;
  logic [15:0] time_left;

  always #5 clk = ~clk;

  irrigation_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .tick_i                   (tick),
    .high_level_indicator_i   (high),
    .middle_level_indicator_i (mid),
    .low_level_indicator_i    (low),
    .soil_humidity_i          (soil),
    .air_humidity_i           (air),
    .start_i                  (start),
    .ack_i                    (ack),
    .sprinkler_o              (sprinkler),
    .drip_o                   (drip),
    .inlet_valve_o            (inlet),
    .alarm_o                  (alarm),
    .error_o                  (error),
    .state_o                  (state),
    .time_o                   (time_left)
  );

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] tm;
    logic        alarm;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sec_to_bcd(input int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // Alarm and error expectations come from the levels being driven right now.
  task automatic expect_st(input string tag, input logic [2:0] st, input logic [15:0] tm);
    exp_t e;
    e.tag   = tag;
    e.st    = st;
    e.tm    = tm;
    e.alarm = (st == FAULT) || !low;
    e.err   = (high && !mid) || (mid && !low);
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({e.tag, ".state"}, 32'(state), 32'(e.st));
      check_eq({e.tag, ".time"}, 32'(time_left), 32'(e.tm));
      check_eq({e.tag, ".valves"}, 32'({sprinkler, drip, inlet}),
               32'({e.st == SPRINKLE, e.st == DRIP, e.st == FILL}));
      check_eq({e.tag, ".alarm"}, 32'(alarm), 32'(e.alarm));
      check_eq({e.tag, ".error"}, 32'(error), 32'(e.err));
      check_eq({e.tag, ".onehot"}, 32'($countones({sprinkler, drip, inlet}) <= 1), 32'd1);
    end
  endtask

  task automatic run_ticks(input int n, input logic [2:0] st, input int start_sec,
                           input string tag);
    for (int k = 1; k <= n; k++) begin
      tick = 1'b1;
      expect_st(tag, st, sec_to_bcd(start_sec - k));
      step();
    end
    tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; high = 1'b0; mid = 1'b1; low = 1'b1;
    soil = 1'b0; air = 1'b0; start = 1'b0; ack = 1'b0;

    // Reset overrides a dry-soil request; alarm follows the low sensor during reset.
    expect_st("reset", IDLE, 16'h0000); step();
    low = 1'b0;
    expect_st("reset_alarm", IDLE, 16'h0000); step();
    low = 1'b1;
    rst_n = 1'b1;
    expect_st("dry_check", CHECK, 16'h0000); step();

    // Tick during the load cycle is ignored.
    tick = 1'b1; soil = 1'b1;
    expect_st("spr_load", SPRINKLE, 16'h0300); step();
    tick = 1'b0;
    run_ticks(180, SPRINKLE, 180, "spr_run");
    tick = 1'b1;
    expect_st("spr_done", IDLE, 16'h0000); step();
    tick = 1'b0;
    expect_st("idle_hold", IDLE, 16'h0000); step();

    // Sprinkle to drip on mid loss, counter kept.
    start = 1'b1;
    expect_st("start", CHECK, 16'h0000); step();
    start = 1'b0;
    expect_st("spr2_load", SPRINKLE, 16'h0300); step();
    run_ticks(60, SPRINKLE, 180, "spr2_run");
    mid = 1'b0;
    expect_st("to_drip", DRIP, 16'h0200); step();
    tick = 1'b1;
    expect_st("drip_tick", DRIP, 16'h0159); step();
    tick = 1'b0;
    expect_st("drip_hold", DRIP, 16'h0159); step();

    // Low tank during drip: fill loads even with a tick present, then fills up.
    low = 1'b0; tick = 1'b1;
    expect_st("fill_load", FILL, 16'h0130); step();
    tick = 1'b0;
    run_ticks(10, FILL, 90, "fill_run");
    high = 1'b1; mid = 1'b1; low = 1'b1;
    expect_st("fill_full", IDLE, 16'h0000); step();

    // Refill timeout.
    high = 1'b0; mid = 1'b0; low = 1'b0;
    expect_st("fill2_load", FILL, 16'h0130); step();
    low = 1'b1;
    run_ticks(90, FILL, 90, "fill2_run");
    tick = 1'b1;
    expect_st("fill_timeout", FAULT, 16'h0000); step();
    tick = 1'b0;
    expect_st("fault_hold", FAULT, 16'h0000); step();
    ack = 1'b1;
    expect_st("ack_ok", IDLE, 16'h0000); step();
    ack = 1'b0;

    // Sensor inconsistency fault; ack ignored while it persists.
    high = 1'b1; mid = 1'b0; low = 1'b1;
    expect_st("err_fault", FAULT, 16'h0000); step();
    ack = 1'b1;
    expect_st("ack_ignored", FAULT, 16'h0000); step();
    ack = 1'b0; high = 1'b0; mid = 1'b1;
    expect_st("err_clear_hold", FAULT, 16'h0000); step();
    ack = 1'b1;
    expect_st("ack_exit", IDLE, 16'h0000); step();
    ack = 1'b0;

    // Reset in the middle of a sprinkle run at 01:23.
    start = 1'b1;
    expect_st("start3", CHECK, 16'h0000); step();
    start = 1'b0;
    expect_st("spr3_load", SPRINKLE, 16'h0300); step();
    run_ticks(97, SPRINKLE, 180, "spr3_run");
    rst_n = 1'b0; tick = 1'b1;
    expect_st("rst_mid", IDLE, 16'h0000); step();
    rst_n = 1'b1; tick = 1'b0;
    expect_st("rst_after", IDLE, 16'h0000); step();

    // Humid air selects drip.
    start = 1'b1; air = 1'b1;
    expect_st("start4", CHECK, 16'h0000); step();
    start = 1'b0;
    expect_st("air_drip", DRIP, 16'h0500); step();
    tick = 1'b1;
    expect_st("air_drip_tick", DRIP, 16'h0459); step();
    tick = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 Parameter SPRINKLE_MMSS, default 16'h0300, sprinkler run time as 4-digit BCD mm:ss.
REQ-002 Parameter DRIP_MMSS, default 16'h0500, drip run time as 4-digit BCD mm:ss.
REQ-003 Parameter FILL_MMSS, default 16'h0130, tank-refill timeout as 4-digit BCD mm:ss.
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 tick_i  input  1  one-cycle 1 Hz enable pulse from the frequency divider.
REQ-007 high_level_indicator_i / middle_level_indicator_i / low_level_indicator_i  input  1 each  tank sensors, 1 = water at that level.
REQ-008 soil_humidity_i  input  1  1 = soil wet, 0 = soil dry.
REQ-009 air_humidity_i  input  1  1 = humid air.
REQ-010 start_i  input  1  debounced one-cycle manual-start pulse.
REQ-011 ack_i  input  1  one-cycle fault-acknowledge pulse.
REQ-012 sprinkler_o, drip_o, inlet_valve_o, alarm_o, error_o  output  1 each  actuator and status flags.
REQ-013 state_o  output  3  encoded FSM state for display.
REQ-014 time_o  output  16  remaining time, BCD {min_tens, min_units, sec_tens, sec_units}.

Function
REQ-015 error = (high & ~middle) | (middle & ~low), combinational; error_o SHALL equal it.
REQ-016 States and encodings: IDLE=0, CHECK=1, SPRINKLE=2, DRIP=3, FILL=4, FAULT=5; codes 6-7 SHALL go to IDLE next cycle.
REQ-017 Transition priority every cycle: error -> FAULT, then ~low -> FILL, then state-specific rules.
REQ-018 IDLE: (start_i | ~soil_humidity_i) -> CHECK; otherwise stay; counter held at 0000.
REQ-019 CHECK (one cycle): middle & ~air_humidity_i -> SPRINKLE, with counter loaded from SPRINKLE_MMSS; else -> DRIP, with counter loaded from DRIP_MMSS.
REQ-020 SPRINKLE: tick_i at counter 0000 -> IDLE.
REQ-021 SPRINKLE: middle=0 -> DRIP, counter value retained (no reload).
REQ-022 SPRINKLE: otherwise decrement on tick_i.
REQ-023 DRIP: tick_i at 0000 -> IDLE; otherwise decrement on tick_i; soil becoming wet SHALL NOT abort a run.
REQ-024 FILL entry: counter loaded from FILL_MMSS in the transition cycle.
REQ-025 FILL: high=1 -> IDLE.
REQ-026 FILL: tick_i at 0000 -> FAULT (refill timeout).
REQ-027 FILL: otherwise decrement on tick_i; the ~low rule SHALL NOT re-enter or reload FILL while already in FILL.
REQ-028 FAULT: counter cleared to 0000; exit to IDLE only on ack_i & ~error; ack_i with error=1 SHALL be ignored.
REQ-029 BCD decrement: sec_units 0->9 with borrow; sec_tens 0->5 with borrow; min_units 0->9 with borrow; min_tens decrements; no wrap below 0000 (expiry instead).
REQ-030 tick_i in a load cycle (CHECK exit, FILL entry) SHALL be ignored; the load wins.
REQ-031 Outputs SHALL be decoded from the state register only: sprinkler_o=(state==SPRINKLE), drip_o=(state==DRIP), inlet_valve_o=(state==FILL).
REQ-032 alarm_o = (state==FAULT) | ~low; state_o = state; time_o = counter.
REQ-033 Latency: an input change is reflected on the actuator outputs exactly one clk later.
REQ-034 At most one of sprinkler_o, drip_o, inlet_valve_o SHALL be 1 in any cycle.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force state IDLE and counter 0000, overriding all inputs, including mid-run or mid-fill.
REQ-036 After reset, sprinkler_o, drip_o and inlet_valve_o SHALL be 0, state_o=0 and time_o=16'h0000.
REQ-037 After reset, alarm_o and error_o SHALL follow the sensor inputs.

Verification
REQ-038 Levels h/m/l=0/1/1, air=0, soil=0 -> CHECK, then SPRINKLE with time_o=0300; 180 ticks later -> IDLE, sprinkler_o=0.
REQ-039 In SPRINKLE at time_o=0200, drop middle to 0 -> DRIP next cycle with time_o=0200; next tick gives 0159.
REQ-040 Set low=0 during DRIP -> FILL, time_o=0130, inlet_valve_o=1; set high=1, middle=1, low=1 after 10 ticks -> IDLE.
REQ-041 FILL with high held at 0 -> after 90 ticks, FAULT with alarm_o=1; ack_i with error=0 -> IDLE.
REQ-042 Levels h/m/l=1/0/1 in any state -> FAULT and error_o=1; ack_i while the levels remain 1/0/1 -> stays in FAULT.
REQ-043 rst_n=0 for one cycle mid-SPRINKLE at time_o=0123 -> IDLE, time_o=0000, all valve outputs 0 on the following cycle.
